// File: rtl/program_loader.sv
// Byte-stream loader: parses SYNC/address/count/data/checksum frames from a UART and
// writes 32-bit words into the CPU program memory, releasing the CPU on a good checksum.
module program_loader #(
  parameter int         DATA_SIZE      = 32,
  parameter int         ADRS_WIDTH     = 11,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  sys_clk,
  input  logic                  resetn,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [DATA_SIZE-1:0]  w_instruction,
  output logic [ADRS_WIDTH-1:0] w_adrs,
  output logic                  w_enable,
  output logic                  cpu_en,
  output logic                  busy,
  output logic                  error,
  output logic [2:0]            dbg_state
);

  // Handshake: rx_valid is a one-cycle strobe with no backpressure; every strobed byte
  // is consumed in the cycle it is presented. w_enable is a one-cycle write strobe and
  // w_adrs/w_instruction are only meaningful (and otherwise hold) around it.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_CNT_HI  = 3'd3,
    S_CNT_LO  = 3'd4,
    S_DATA    = 3'd5,
    S_CHK     = 3'd6
  } state_t;

  localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_n;
  logic [7:0]            chk_q, chk_n;
  logic [TW-1:0]         tcnt_q, tcnt_n;
  logic [ADRS_WIDTH-1:0] addr_q, addr_n;
  logic [7:0]            hi_q, hi_n;
  logic [15:0]           words_q, words_n;
  logic [1:0]            bidx_q, bidx_n;
  logic [23:0]           shift_q, shift_n;
  logic [DATA_SIZE-1:0]  winst_n;
  logic [ADRS_WIDTH-1:0] wadrs_n;
  logic                  wen_n, cpu_en_n, error_n;
  logic [15:0]           pair16;

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      chk_q         <= '0;
      tcnt_q        <= '0;
      addr_q        <= '0;
      hi_q          <= '0;
      words_q       <= '0;
      bidx_q        <= '0;
      shift_q       <= '0;
      w_instruction <= '0;
      w_adrs        <= '0;
      w_enable      <= 1'b0;
      cpu_en        <= 1'b0;
      error         <= 1'b0;
    end else begin
      state_q       <= state_n;
      chk_q         <= chk_n;
      tcnt_q        <= tcnt_n;
      addr_q        <= addr_n;
      hi_q          <= hi_n;
      words_q       <= words_n;
      bidx_q        <= bidx_n;
      shift_q       <= shift_n;
      w_instruction <= winst_n;
      w_adrs        <= wadrs_n;
      w_enable      <= wen_n;
      cpu_en        <= cpu_en_n;
      error         <= error_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    chk_n    = chk_q;
    tcnt_n   = tcnt_q;
    addr_n   = addr_q;
    hi_n     = hi_q;
    words_n  = words_q;
    bidx_n   = bidx_q;
    shift_n  = shift_q;
    winst_n  = w_instruction;
    wadrs_n  = w_adrs;
    wen_n    = 1'b0;
    cpu_en_n = cpu_en;
    error_n  = error;
    pair16   = {hi_q, rx_data};

    if (state_q == S_IDLE) begin
      tcnt_n = '0;
      if (rx_valid && rx_data == SYNC_BYTE) begin
        state_n  = S_ADDR_HI;
        cpu_en_n = 1'b0;
        error_n  = 1'b0;
        chk_n    = '0;
      end
    end else if (rx_valid) begin
      // An arriving byte always wins over an expiring timeout.
      tcnt_n = '0;
      if (state_q != S_CHK) chk_n = chk_q ^ rx_data;
      case (state_q)
        S_ADDR_HI: begin
          hi_n    = rx_data;
          state_n = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_n  = pair16[ADRS_WIDTH-1:0];
          state_n = S_CNT_HI;
        end
        S_CNT_HI: begin
          hi_n    = rx_data;
          state_n = S_CNT_LO;
        end
        S_CNT_LO: begin
          words_n = pair16;
          bidx_n  = 2'd0;
          state_n = (pair16 == 16'd0) ? S_CHK : S_DATA;
        end
        S_DATA: begin
          bidx_n  = bidx_q + 2'd1;
          shift_n = {shift_q[15:0], rx_data};
          if (bidx_q == 2'd3) begin
            wen_n   = 1'b1;
            winst_n = DATA_SIZE'({shift_q, rx_data});
            wadrs_n = addr_q;
            addr_n  = addr_q + 1'b1;
            words_n = words_q - 16'd1;
            if (words_q == 16'd1) state_n = S_CHK;
          end
        end
        S_CHK: begin
          state_n = S_IDLE;
          if (rx_data == chk_q) begin
            cpu_en_n = 1'b1;
            error_n  = 1'b0;
          end else begin
            error_n  = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end else if (tcnt_q == T_LAST) begin
      state_n = S_IDLE;
      tcnt_n  = '0;
      error_n = 1'b1;
    end else begin
      tcnt_n = tcnt_q + 1'b1;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of frames plus hand-written reset, timeout and
// stray-byte sequences; writes are checked against an expected queue with cycle stamps.
module tb_program_loader;
  localparam int T = 16;
  localparam int W = 59;  // {cycle[15:0], adrs[10:0], word[31:0]}

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] w_instruction;
  logic [10:0] w_adrs;
  logic        w_enable, cpu_en, busy, error;
  logic [2:0]  dbg_state;

  program_loader #(.TIMEOUT_CYCLES(T)) dut (
    .sys_clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .w_instruction(w_instruction), .w_adrs(w_adrs), .w_enable(w_enable),
    .cpu_en(cpu_en), .busy(busy), .error(error), .dbg_state(dbg_state)
  );

  // Clock and cycle stamp
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    string       name;
    logic [15:0] addr;
    int          nw;
    logic [31:0] words[4];
    bit          bad;
    logic [7:0]  bad_chk;
    bit          exp_cpu_en;
    bit          exp_error;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: each write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (resetn && w_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_write: adrs %0h data %0h with nothing expected", w_adrs, w_instruction);
      end else begin
        logic [15:0] c16;
        c16 = cyc[15:0];
        check("write", {c16, w_adrs, w_instruction}, exp_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame; optional silent gap after ADDR_HI; model computes checksum and writes
  task automatic send_frame(input vec_t v, input int gap);
    logic [7:0]  c;
    logic [7:0]  b;
    logic [10:0] a;
    logic [15:0] n16;
    logic [15:0] stamp;
    c   = 8'h00;
    a   = v.addr[10:0];
    n16 = 16'(v.nw);
    send_byte(8'hA5);
    check({v.name, "_sync_busy"}, busy, 1);
    check({v.name, "_sync_error"}, error, 0);
    check({v.name, "_sync_cpu_en"}, cpu_en, 0);
    c ^= v.addr[15:8];
    send_byte(v.addr[15:8]);
    if (gap > 0) begin
      idle(gap);
      check({v.name, "_gap_busy"}, busy, 1);
    end
    c ^= v.addr[7:0];
    send_byte(v.addr[7:0]);
    c ^= n16[15:8];
    send_byte(n16[15:8]);
    c ^= n16[7:0];
    send_byte(n16[7:0]);
    for (int i = 0; i < v.nw; i++) begin
      for (int j = 3; j >= 0; j--) begin
        b = v.words[i][8*j +: 8];
        c ^= b;
        if (j == 0) begin
          stamp = 16'(cyc + 1);
          exp_q.push_back({stamp, a, v.words[i]});
          a = a + 11'd1;
        end
        send_byte(b);
      end
    end
    send_byte(v.bad ? v.bad_chk : c);
    check({v.name, "_cpu_en"}, cpu_en, v.exp_cpu_en);
    check({v.name, "_error"}, error, v.exp_error);
    check({v.name, "_busy_done"}, busy, 0);
    check({v.name, "_writes_drained"}, exp_q.size(), 0);
    if (v.nw > 0) begin
      check({v.name, "_adrs_hold"}, w_adrs, a - 11'd1);
      check({v.name, "_instr_hold"}, w_instruction, v.words[v.nw-1]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vt[0] = '{"mult", 16'h0000, 3, '{32'h0000000D, 32'h0000000B, 32'h00000000, 32'h0}, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[1] = '{"badchk", 16'h0000, 3, '{32'h0000000D, 32'h0000000B, 32'h00000000, 32'h0}, 1'b1, 8'h08, 1'b0, 1'b1};
    vt[2] = '{"wrap", 16'h07FF, 2, '{32'h11111111, 32'h22222222, 32'h0, 32'h0}, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[3] = '{"n0", 16'h0010, 0, '{32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[4] = '{"a5data", 16'h0100, 2, '{32'hA5A5A5A5, 32'h12345678, 32'h0, 32'h0}, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[5] = '{"upper", 16'hF805, 1, '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[6] = '{"random", 16'($urandom_range(0, 65535)), 4,
              '{$urandom, $urandom, $urandom, $urandom}, 1'b0, 8'h00, 1'b1, 1'b0};

    // Reset state
    resetn = 1'b0;
    idle(3);
    check("rst_w_enable", w_enable, 0);
    check("rst_w_adrs", w_adrs, 0);
    check("rst_w_instruction", w_instruction, 0);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_state", dbg_state, 0);
    resetn = 1'b1;
    idle(1);
    send_byte(8'h00);
    check("idle_nonsync_busy", busy, 0);

    for (int k = 0; k < 7; k++) begin
      send_frame(vt[k], 0);
      idle($urandom_range(0, 3));
    end

    // Stray byte in IDLE with CPU running
    send_byte(8'h3C);
    check("stray_busy", busy, 0);
    check("stray_cpu_en", cpu_en, 1);

    // Reset in the middle of a frame
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    check("midframe_busy", busy, 1);
    resetn = 1'b0;
    #1;
    check("midrst_w_adrs", w_adrs, 0);
    check("midrst_w_instruction", w_instruction, 0);
    check("midrst_cpu_en", cpu_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_error", error, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(1);
    send_byte(8'h00);
    check("postrst_busy", busy, 0);

    // Timeout fires after T silent cycles
    send_byte(8'hA5);
    send_byte(8'h00);
    idle(T - 1);
    check("to_before_busy", busy, 1);
    check("to_before_error", error, 0);
    idle(1);
    check("to_busy", busy, 0);
    check("to_error", error, 1);
    check("to_cpu_en", cpu_en, 0);
    check("to_state", dbg_state, 0);

    // Byte on the exact timeout cycle is accepted
    v = '{"late", 16'h0000, 1, '{32'hCAFEF00D, 32'h0, 32'h0, 32'h0}, 1'b0, 8'h00, 1'b1, 1'b0};
    send_frame(v, T - 1);

    idle(2);
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
